ex_muldiv_iter: RTL and testbench

- Parametrised iterative RV-M execute unit; sits beside the EX-stage ALU and takes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Generalised in operand width (XLEN) and in retired bits per cycle (BPC).
- Runs as a multi-cycle FSM and holds the pipeline via busy until the result is delivered toward MA.
- Honours jump purge (abort) and the global pipeline stall (result hold).

---
 rtl/ex_muldiv_iter_if.sv | 48 ++++
 rtl/ex_muldiv_iter.sv | 182 ++++++++++++++++++
 tb/tb_ex_muldiv_iter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_iter_if.sv
// rtl/ex_muldiv_iter_if.sv - request/result bundle between the EX stage and the iterative mul/div unit
//
// Purpose: groups the request, pipeline-control and result signals of
// ex_muldiv_iter so the unit can be bound with a single interface port.
//
// Signals (master = pipeline side, slave = ex_muldiv_iter):
//   start           m->s  one-cycle request, already qualified by ID
//   alu_code_ex     m->s  funct3 of the M-extension opcode
//   rs1_sel         m->s  forwarded operand 1
//   rs2_sel         m->s  forwarded operand 2
//   rd_adr_ex       m->s  destination register of the request
//   wbk_rd_reg_ex   m->s  writeback enable of the request
//   jmp_purge_ma    m->s  jump purge, kills an operation in flight
//   stall           m->s  global pipeline stall
//   busy            s->m  stall request toward the pipeline
//   done            s->m  result valid toward MA
//   result          s->m  product half, quotient or remainder
//   rd_adr_out      s->m  latched destination register
//   wbk_rd_reg_out  s->m  latched writeback enable, qualified by done
interface ex_muldiv_iter_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      alu_code_ex;
   logic [XLEN-1:0] rs1_sel;
   logic [XLEN-1:0] rs2_sel;
   logic [4:0]      rd_adr_ex;
   logic            wbk_rd_reg_ex;
   logic            jmp_purge_ma;
   logic            stall;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_adr_out;
   logic            wbk_rd_reg_out;

   modport master (
      output start, alu_code_ex, rs1_sel, rs2_sel, rd_adr_ex, wbk_rd_reg_ex,
             jmp_purge_ma, stall,
      input  busy, done, result, rd_adr_out, wbk_rd_reg_out
   );

   modport slave (
      input  start, alu_code_ex, rs1_sel, rs2_sel, rd_adr_ex, wbk_rd_reg_ex,
             jmp_purge_ma, stall,
      output busy, done, result, rd_adr_out, wbk_rd_reg_out
   );
endinterface

// File: rtl/ex_muldiv_iter.sv
// rtl/ex_muldiv_iter.sv - iterative RV-M multiply/divide execute unit
//
// Purpose: multi-cycle MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU beside the
// EX-stage ALU. Works on operand magnitudes, retiring BPC bits per CALC
// cycle (shift-add for multiply, restoring division for divide), then
// applies the sign correction and output selection in FIX.
//
// Ports:
//   clk   clock, all state on the rising edge
//   rst   asynchronous active-high reset
//   bus   ex_muldiv_iter_if.slave: request, purge/stall and result signals
//
// Parameters:
//   XLEN  operand/result width, a multiple of BPC
//   BPC   bits retired per CALC cycle (1, 2 or 4)
module ex_muldiv_iter #(
   parameter int XLEN = 32,
   parameter int BPC  = 1
) (
   input  logic              clk,
   input  logic              rst,
   ex_muldiv_iter_if.slave   bus
);
   localparam int ITER = XLEN / BPC;
   localparam int CW   = $clog2(ITER + 1);
   localparam int PW   = XLEN + BPC;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   // Shared accumulator: multiply = {partial high, remaining multiplier},
   // divide = {partial remainder, remaining dividend / quotient bits}.
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   opb;
   logic [2:0]        code;
   logic              neg_qp;
   logic              neg_r;
   logic              busy_q;
   logic              done_q;
   logic              wbk_q;
   logic [XLEN-1:0]   result_q;
   logic [4:0]        rd_q;

   // Request decode: signedness, magnitudes and the short-cut cases.
   logic              signed_a, signed_b, neg_a, neg_b;
   logic              div_zero, div_ovf, special;
   logic [XLEN-1:0]   mag_a, mag_b;

   always_comb begin
      signed_a = bus.alu_code_ex[2] ? ~bus.alu_code_ex[0] : (bus.alu_code_ex[1:0] != 2'b11);
      signed_b = bus.alu_code_ex[2] ? ~bus.alu_code_ex[0] : ~bus.alu_code_ex[1];
      neg_a    = signed_a & bus.rs1_sel[XLEN-1];
      neg_b    = signed_b & bus.rs2_sel[XLEN-1];
      mag_a    = neg_a ? -bus.rs1_sel : bus.rs1_sel;
      mag_b    = neg_b ? -bus.rs2_sel : bus.rs2_sel;
      div_zero = bus.alu_code_ex[2] & (bus.rs2_sel == '0);
      div_ovf  = bus.alu_code_ex[2] & ~bus.alu_code_ex[0]
               & (bus.rs1_sel == MIN_NEG) & (bus.rs2_sel == '1);
      special  = div_zero | div_ovf;
   end

   // One CALC step of each algorithm.
   logic [PW-1:0]     partial, hi_sum;
   logic [2*XLEN-1:0] mul_next, div_next;
   logic [XLEN:0]     rem_w;
   logic [XLEN-1:0]   quo_w;

   always_comb begin
      partial  = PW'(opb) * PW'(acc[BPC-1:0]);
      hi_sum   = PW'(acc[2*XLEN-1:XLEN]) + partial;
      mul_next = {hi_sum, acc[XLEN-1:BPC]};

      rem_w = {1'b0, acc[2*XLEN-1:XLEN]};
      quo_w = acc[XLEN-1:0];
      for (int i = 0; i < BPC; i++) begin
         rem_w = {rem_w[XLEN-1:0], quo_w[XLEN-1]};
         quo_w = {quo_w[XLEN-2:0], 1'b0};
         if (rem_w >= {1'b0, opb}) begin
            rem_w    = rem_w - {1'b0, opb};
            quo_w[0] = 1'b1;
         end
      end
      div_next = {rem_w[XLEN-1:0], quo_w};
   end

   // Sign correction and output selection. Special cases are preloaded
   // with their final values and cleared sign flags, so they pass through.
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

   always_comb begin
      prod    = neg_qp ? -acc : acc;
      quo_fix = neg_qp ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem_fix = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      case (code)
         3'd0:         fix_result = prod[XLEN-1:0];
         3'd1, 3'd2,
         3'd3:         fix_result = prod[2*XLEN-1:XLEN];
         3'd4, 3'd5:   fix_result = quo_fix;
         default:      fix_result = rem_fix;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         opb      <= '0;
         code     <= '0;
         neg_qp   <= 1'b0;
         neg_r    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         wbk_q    <= 1'b0;
         result_q <= '0;
         rd_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start && !bus.jmp_purge_ma) begin
                  code   <= bus.alu_code_ex;
                  rd_q   <= bus.rd_adr_ex;
                  wbk_q  <= bus.wbk_rd_reg_ex;
                  opb    <= mag_b;
                  cnt    <= CW'(ITER - 1);
                  busy_q <= 1'b1;
                  if (special) begin
                     acc    <= div_zero ? {bus.rs1_sel, {XLEN{1'b1}}}
                                        : {{XLEN{1'b0}}, bus.rs1_sel};
                     neg_qp <= 1'b0;
                     neg_r  <= 1'b0;
                     state  <= FIX;
                  end else begin
                     acc    <= {{XLEN{1'b0}}, mag_a};
                     neg_qp <= neg_a ^ neg_b;
                     neg_r  <= neg_a;
                     state  <= CALC;
                  end
               end
            end
            CALC: begin
               if (bus.jmp_purge_ma) begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end else begin
                  acc <= code[2] ? div_next : mul_next;
                  cnt <= cnt - 1'b1;
                  if (cnt == '0) state <= FIX;
               end
            end
            FIX: begin
               busy_q <= 1'b0;
               if (bus.jmp_purge_ma) begin
                  state <= IDLE;
               end else begin
                  result_q <= fix_result;
                  done_q   <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               // Past the purge point: only the pipeline stall can hold us here.
               if (!bus.stall) begin
                  done_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Holding DONE under stall must keep the pipeline frozen as well.
   assign bus.busy           = busy_q | (done_q & bus.stall);
   assign bus.done           = done_q;
   assign bus.result         = result_q;
   assign bus.rd_adr_out     = rd_q;
   assign bus.wbk_rd_reg_out = wbk_q & done_q;
endmodule

// File: tb/tb_ex_muldiv_iter.sv
// tb/tb_ex_muldiv_iter.sv - scoreboard bench for ex_muldiv_iter (32/1 and 16/4)
module tb_ex_muldiv_iter;
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   ntests = 0;
   int   nfail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ex_muldiv_iter_if #(.XLEN(32)) b32 ();
   ex_muldiv_iter_if #(.XLEN(16)) b16 ();

   ex_muldiv_iter #(.XLEN(32), .BPC(1)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
   ex_muldiv_iter #(.XLEN(16), .BPC(4)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          issue;
      int          lat;
      string       name;
   } exp_t;

   exp_t sb32[$];
   exp_t sb16[$];
   logic prev32 = 1'b0;
   logic prev16 = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      ntests++;
      if (act !== req) begin
         nfail++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Monitors: one response per rising edge of done.
   always @(negedge clk) begin
      exp_t e;
      if (b32.done && !prev32) begin
         if (sb32.size() == 0) begin
            chk("unexpected_done32", 1, 0);
         end else begin
            e = sb32.pop_front();
            chk({e.name, "_result"}, b32.result, e.res);
            chk({e.name, "_rd"}, b32.rd_adr_out, e.rd);
            chk({e.name, "_wbk"}, b32.wbk_rd_reg_out, 1);
            chk({e.name, "_latency"}, cyc - e.issue, e.lat);
         end
      end
      prev32 <= b32.done;
   end

   always @(negedge clk) begin
      exp_t e;
      if (b16.done && !prev16) begin
         if (sb16.size() == 0) begin
            chk("unexpected_done16", 1, 0);
         end else begin
            e = sb16.pop_front();
            chk({e.name, "_result"}, b16.result, e.res);
            chk({e.name, "_rd"}, b16.rd_adr_out, e.rd);
            chk({e.name, "_latency"}, cyc - e.issue, e.lat);
         end
      end
      prev16 <= b16.done;
   end

   task automatic op32(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input string nm,
                       input bit special);
      exp_t e;
      int   n;
      bit   seen;
      @(negedge clk);
      b32.alu_code_ex   = code;
      b32.rs1_sel       = a;
      b32.rs2_sel       = b;
      b32.rd_adr_ex     = rd;
      b32.wbk_rd_reg_ex = 1'b1;
      b32.start         = 1'b1;
      e.res = res; e.rd = rd; e.issue = cyc; e.lat = special ? 2 : 34; e.name = nm;
      sb32.push_back(e);
      @(negedge clk);
      b32.start = 1'b0;
      n = 0;
      seen = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (b32.done) begin
            seen = 1'b1;
            break;
         end
         if (b32.busy) n++;
         @(negedge clk);
      end
      chk({nm, "_done_seen"}, seen, 1);
      chk({nm, "_busy_cycles"}, n, special ? 1 : 33);
      if (!b32.stall) @(negedge clk);
   endtask

   task automatic op16(input logic [2:0] code, input logic [15:0] a, input logic [15:0] b,
                       input logic [4:0] rd, input logic [15:0] res, input string nm);
      exp_t e;
      int   n;
      bit   seen;
      @(negedge clk);
      b16.alu_code_ex   = code;
      b16.rs1_sel       = a;
      b16.rs2_sel       = b;
      b16.rd_adr_ex     = rd;
      b16.wbk_rd_reg_ex = 1'b1;
      b16.start         = 1'b1;
      e.res = {16'h0, res}; e.rd = rd; e.issue = cyc; e.lat = 6; e.name = nm;
      sb16.push_back(e);
      @(negedge clk);
      b16.start = 1'b0;
      n = 0;
      seen = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (b16.done) begin
            seen = 1'b1;
            break;
         end
         if (b16.busy) n++;
         @(negedge clk);
      end
      chk({nm, "_done_seen"}, seen, 1);
      chk({nm, "_busy_cycles"}, n, 5);
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] held_res;
      bit          seen;
      rst = 1'b1;
      b32.start = 0; b32.alu_code_ex = 0; b32.rs1_sel = 0; b32.rs2_sel = 0;
      b32.rd_adr_ex = 0; b32.wbk_rd_reg_ex = 0; b32.jmp_purge_ma = 0; b32.stall = 0;
      b16.start = 0; b16.alu_code_ex = 0; b16.rs1_sel = 0; b16.rs2_sel = 0;
      b16.rd_adr_ex = 0; b16.wbk_rd_reg_ex = 0; b16.jmp_purge_ma = 0; b16.stall = 0;
      repeat (2) @(negedge clk);
      chk("reset_busy", b32.busy, 0);
      chk("reset_done", b32.done, 0);
      chk("reset_result", b32.result, 0);
      chk("reset_rd", b32.rd_adr_out, 0);
      chk("reset_wbk", b32.wbk_rd_reg_out, 0);
      rst = 1'b0;
      @(negedge clk);

      op32(3'd0, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, "mul", 0);
      op32(3'd1, 32'd7, 32'hFFFFFFFD, 5'd2, 32'hFFFFFFFF, "mulh", 0);
      op32(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, "mulhu", 0);
      op32(3'd2, 32'hFFFFFFFF, 32'd2, 5'd4, 32'hFFFFFFFF, "mulhsu", 0);
      op32(3'd4, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, "div_neg", 0);
      op32(3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, "rem_neg", 0);
      op32(3'd4, 32'd7, 32'hFFFFFFFE, 5'd7, 32'hFFFFFFFD, "div_negb", 0);
      op32(3'd6, 32'd7, 32'hFFFFFFFE, 5'd8, 32'h00000001, "rem_negb", 0);
      op32(3'd5, 32'd100, 32'd7, 5'd9, 32'd14, "divu", 0);
      op32(3'd7, 32'd100, 32'd7, 5'd10, 32'd2, "remu", 0);

      op32(3'd4, 32'd5, 32'd0, 5'd11, 32'hFFFFFFFF, "div_by0", 1);
      op32(3'd6, 32'd5, 32'd0, 5'd12, 32'd5, "rem_by0", 1);
      op32(3'd5, 32'd5, 32'd0, 5'd13, 32'hFFFFFFFF, "divu_by0", 1);
      op32(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, "div_ovf", 1);
      op32(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h0, "rem_ovf", 1);

      // start together with purge in IDLE is dropped
      @(negedge clk);
      b32.alu_code_ex = 3'd5; b32.rs1_sel = 32'd9; b32.rs2_sel = 32'd3;
      b32.start = 1'b1; b32.jmp_purge_ma = 1'b1;
      @(negedge clk);
      b32.start = 1'b0; b32.jmp_purge_ma = 1'b0;
      chk("purge_idle_busy", b32.busy, 0);

      // purge in CALC cycle 10
      b32.alu_code_ex = 3'd5; b32.rs1_sel = 32'd100; b32.rs2_sel = 32'd7;
      b32.start = 1'b1;
      @(negedge clk);
      b32.start = 1'b0;
      repeat (9) @(negedge clk);
      b32.jmp_purge_ma = 1'b1;
      @(negedge clk);
      b32.jmp_purge_ma = 1'b0;
      chk("purge_calc_busy", b32.busy, 0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (b32.done) seen = 1'b1;
      end
      chk("purge_calc_no_done", seen, 0);
      op32(3'd5, 32'd9, 32'd3, 5'd16, 32'd3, "divu_after_purge", 0);

      // stall held while in DONE
      b32.stall = 1'b1;
      op32(3'd5, 32'd1000, 32'd10, 5'd17, 32'd100, "divu_stall", 0);
      held_res = b32.result;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_done_hold", b32.done, 1);
         chk("stall_result_hold", b32.result, held_res);
         chk("stall_rd_hold", b32.rd_adr_out, 5'd17);
         chk("stall_busy", b32.busy, 1);
      end
      b32.stall = 1'b0;
      @(negedge clk);
      chk("stall_release_done", b32.done, 0);
      chk("stall_release_busy", b32.busy, 0);
      chk("result_kept_after_done", b32.result, 32'd100);

      // reset mid-CALC
      b32.alu_code_ex = 3'd5; b32.rs1_sel = 32'd100; b32.rs2_sel = 32'd7;
      b32.rd_adr_ex = 5'd20; b32.start = 1'b1;
      @(negedge clk);
      b32.start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid_busy", b32.busy, 0);
      chk("rst_mid_done", b32.done, 0);
      chk("rst_mid_result", b32.result, 0);
      chk("rst_mid_rd", b32.rd_adr_out, 0);
      chk("rst_mid_wbk", b32.wbk_rd_reg_out, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      op16(3'd5, 16'hFFFF, 16'h0010, 5'd21, 16'h0FFF, "divu16");
      op16(3'd3, 16'hFFFF, 16'h0002, 5'd22, 16'h0001, "mulhu16");

      repeat (3) @(negedge clk);
      chk("sb32_drained", sb32.size(), 0);
      chk("sb16_drained", sb16.size(), 0);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end
endmodule
